// File: rtl/spi_slave_rx_sync.sv
// SPI mode-0 receive slave: synchronized inputs, runtime word length, one-word holding register.
// Optional overrun detection is built only when SPI_SLAVE_RX_OVERRUN_DET_EN is defined.
module spi_slave_rx_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sclk,
  input  logic                          cs,
  input  logic                          mosi,
  input  logic [$clog2(DATA_WIDTH)-1:0] counter_in,
  input  logic                          counter_in_upd,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          data_valid,
  input  logic                          data_ack,
  output logic                          done,
  output logic                          abort,
  output logic                          overrun
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise_s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          counter_q, counter_d;
  logic [CW-1:0]          trgt_q, trgt_d;
  logic                   pend_q, pend_d;
  logic [CW-1:0]          pend_val_q, pend_val_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic                   complete_s;
  logic [DATA_WIDTH-1:0]  shifted_s;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;

  // A new word starts from zero so short words come out zero-extended.
  assign shifted_s = (counter_q == CNT_ZERO) ? {{(DATA_WIDTH-1){1'b0}}, mosi_s}
                                             : {shreg_q[DATA_WIDTH-2:0], mosi_s};

  // Frame FSM, bit counter, shift register and output holding register.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    complete_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        counter_d = CNT_ZERO;
        if (!cs_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise_s) begin
          shreg_d = shifted_s;
          if (counter_q == trgt_q) begin
            counter_d  = CNT_ZERO;
            complete_s = 1'b1;
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
        end else begin
          counter_d = counter_q;
        end
        // Deselect is handled after the same-cycle edge, so that edge may still finish the word.
        if (cs_s) begin
          state_d   = ST_IDLE;
          abort_d   = (counter_d != CNT_ZERO);
          counter_d = CNT_ZERO;
          shreg_d   = {DATA_WIDTH{1'b0}};
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        counter_d = CNT_ZERO;
      end
    endcase
    if (complete_s) begin
      data_d       = shifted_s;
      data_valid_d = 1'b1;
      done_d       = 1'b1;
    end else if (data_ack) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end
  end

  // Word-length updates only take effect between words.
  always_comb begin
    trgt_d     = trgt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (counter_in_upd) begin
      if (counter_q == CNT_ZERO) begin
        trgt_d = counter_in;
        pend_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_val_d = counter_in;
      end
    end else if (pend_q && (counter_q == CNT_ZERO)) begin
      trgt_d = pend_val_q;
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers and synchronizers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_sync_q  <= {SYNC_STAGES{1'b0}};
      cs_sync_q    <= {SYNC_STAGES{1'b1}};
      mosi_sync_q  <= {SYNC_STAGES{1'b0}};
      sclk_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      counter_q    <= CNT_ZERO;
      trgt_q       <= {CW{1'b1}};
      pend_q       <= 1'b0;
      pend_val_q   <= CNT_ZERO;
      shreg_q      <= {DATA_WIDTH{1'b0}};
      data_q       <= {DATA_WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q  <= sclk_s;
      state_q      <= state_d;
      counter_q    <= counter_d;
      trgt_q       <= trgt_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

`ifdef SPI_SLAVE_RX_OVERRUN_DET_EN
  logic overrun_q, overrun_d;

  // Sticky: a finished word landed on top of one that was never taken.
  always_comb begin
    if (complete_s && data_valid_q && !data_ack) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_spi_slave_rx_sync.sv
// Directed + randomized bench for spi_slave_rx_sync with a word-level reference model.
module tb_spi_slave_rx_sync;

  localparam int DW = 32;
  localparam int SS = 2;
`ifdef SPI_SLAVE_RX_OVERRUN_DET_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, sclk, cs, mosi;
  logic [4:0]    counter_in;
  logic          counter_in_upd, data_ack;
  logic [DW-1:0] data;
  logic          data_valid, done, abort, overrun;

  int cyc = 0, done_cnt = 0, abort_cnt = 0, done_cyc = 0, rise_cyc = 0;
  int n_pass = 0, n_fail = 0, n_total = 0;

  int          exp_len;
  logic [31:0] exp_data;
  logic        exp_valid, exp_overrun;
  int          exp_done, exp_abort;

  spi_slave_rx_sync #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .cs(cs), .mosi(mosi),
    .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ack(data_ack),
    .done(done), .abort(abort), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (abort) abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"}, data, exp_data);
    check({tag, ".valid"}, {31'd0, data_valid}, {31'd0, exp_valid});
    check({tag, ".overrun"}, {31'd0, overrun}, {31'd0, exp_overrun});
    check({tag, ".done_cnt"}, done_cnt, exp_done);
    check({tag, ".abort_cnt"}, abort_cnt, exp_abort);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sclk = 1'b0;
      mosi = v[i];
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
    end
  endtask

  // Model: one whole word of the current length was received.
  task automatic model_word(input logic [31:0] v);
    exp_done++;
    if (OVR_EN && exp_valid) exp_overrun = 1'b1;
    exp_valid = 1'b1;
    if (exp_len == 32) exp_data = v;
    else exp_data = v & ((32'h1 << exp_len) - 32'h1);
  endtask

  task automatic send_word(input logic [31:0] v);
    send_bits(v, exp_len);
    model_word(v);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic set_len(input int len);
    @(negedge clk);
    counter_in = 5'(len - 1);
    counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0;
    exp_len = len;
  endtask

  initial begin
    logic [31:0] w;
    rstn = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    counter_in = 5'd0; counter_in_upd = 1'b0; data_ack = 1'b0;
    exp_len = 32; exp_data = 32'h0; exp_valid = 1'b0; exp_overrun = 1'b0;
    exp_done = 0; exp_abort = 0;
    repeat (3) @(negedge clk);
    check("reset.done", {31'd0, done}, 32'd0);
    check_outputs("reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Full 32-bit word at the reset word length.
    frame_start();
    send_word(32'hA5C3_0F81);
    check("w32.data", data, 32'hA5C3_0F81);
    check("w32.latency", done_cyc - rise_cyc, SS + 1);
    frame_end();
    check_outputs("w32.hold");
    ack();
    check("w32.ack", {31'd0, data_valid}, 32'd0);

    // Byte mode, back-to-back bytes in one frame.
    set_len(8);
    frame_start();
    send_word(32'h3C);
    check("byte.data", data, 32'h0000_003C);
    ack();
    send_word(32'hC3);
    check("byte2.data", data, 32'h0000_00C3);
    frame_end();
    check_outputs("byte");

    // Deselect after 5 of 8 bits, then a clean byte.
    frame_start();
    send_bits(32'h15, 5);
    exp_abort++;
    frame_end();
    check_outputs("abort");
    ack();
    frame_start();
    send_word(32'h81);
    frame_end();
    check_outputs("after_abort");
    ack();

    // Two words without consuming the first.
    frame_start();
    send_word(32'h11);
    check("ovr.first", {31'd0, overrun}, {31'd0, exp_overrun});
    send_word(32'h22);
    frame_end();
    check_outputs("ovr");
    ack();

    // Length change requested mid-word.
    frame_start();
    send_bits(32'h5, 4);
    @(negedge clk);
    counter_in = 5'd3;
    counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0;
    send_bits(32'hA, 4);
    model_word(32'h5A);
    check("pend.cur", data, 32'h5A);
    ack();
    exp_len = 4;
    send_word(32'h9);
    check("pend.next", data, 32'h9);
    frame_end();
    check_outputs("pend");

    // Randomized frames: random length, word count and partial tail.
    for (int it = 0; it < 6; it++) begin
      int len, nw, tail;
      len = $urandom_range(1, 32);
      set_len(len);
      nw = $urandom_range(1, 3);
      tail = $urandom_range(0, len - 1);
      frame_start();
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        send_word(w);
        check("rand.word", data, exp_data);
      end
      if (tail > 0) begin
        w = $urandom;
        send_bits(w, tail);
        exp_abort++;
      end
      frame_end();
      check_outputs("rand");
      if ($urandom_range(0, 1) == 1) ack();
    end

    // Reset in the middle of a word.
    set_len(8);
    frame_start();
    send_bits(32'h5, 3);
    @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_data = 32'h0; exp_valid = 1'b0; exp_overrun = 1'b0; exp_len = 32;
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.abort", {31'd0, abort}, 32'd0);
    check_outputs("rst");
    repeat (10) @(negedge clk);
    check("rst.no_abort", abort_cnt, exp_abort);
    w = $urandom;
    send_word(w);
    frame_end();
    check_outputs("rst.len32");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_sync.md
SPI_SLAVE_RX_SYNC -- requirements
Module: spi_slave_rx_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: maximum word length in bits; CW = $clog2(DATA_WIDTH).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer, minimum 2.
REQ-003 SHALL have port clk  input  1: the single system clock; all flops are on its rising edge.
REQ-004 SHALL have port rstn  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port sclk  input  1: SPI clock, asynchronous to clk.
REQ-006 SHALL have port cs  input  1: chip select, asynchronous, high = deselected.
REQ-007 SHALL have port mosi  input  1: SPI serial data in, asynchronous.
REQ-008 SHALL have port counter_in  input  CW: word length minus one.
REQ-009 SHALL have port counter_in_upd  input  1: one-cycle strobe loading counter_in.
REQ-010 SHALL have port data  output  DATA_WIDTH: received word, right-aligned, upper bits zero.
REQ-011 SHALL have port data_valid  output  1: data holds an unconsumed word.
REQ-012 SHALL have port data_ack  input  1: consumer accepts data.
REQ-013 SHALL have port done  output  1: one-cycle pulse when a word completes.
REQ-014 SHALL have port abort  output  1: one-cycle pulse when cs deasserts mid-word.
REQ-015 SHALL have port overrun  output  1: sticky error flag (see Configuration).

Function
REQ-016 SHALL pass sclk, cs and mosi through SYNC_STAGES-deep synchronizers; sclk_s, cs_s and mosi_s denote the synchronized values.
REQ-017 SHALL detect an sclk rising edge as sclk_s=1 with the previous-cycle sclk_s=0 (SPI mode 0 sampling); clk SHALL run at 4x sclk or faster.
REQ-018 SHALL implement FSM IDLE, SHIFT: IDLE->SHIFT when cs_s=0; SHIFT->IDLE when cs_s=1.
REQ-019 SHALL, in SHIFT on each detected edge, shift shreg <= {shreg[DATA_WIDTH-2:0], mosi_s} (MSB first); counter SHALL increment, or clear to 0 when counter==counter_trgt.
REQ-020 SHALL, on the edge where counter==counter_trgt, load data with the completed word, pulse done and set data_valid, one clk after edge detection; the total latency is SYNC_STAGES+1 clk from the first clk sampling sclk high.
REQ-021 SHALL clear shreg to 0 at each word start, so words shorter than DATA_WIDTH are zero-extended.
REQ-022 SHALL clear data_valid on data_ack; when data_ack and a new completion occur in the same cycle, data_valid SHALL stay 1 and data SHALL take the new word.
REQ-023 SHALL hold a counter_in_upd value as pending and apply it to counter_trgt when counter==0, i.e. immediately if idle or at a word boundary, otherwise after the current word.
REQ-024 SHALL, on cs_s rising while counter!=0, pulse abort, discard shreg and leave data and data_valid unchanged; counter SHALL clear to 0.
REQ-025 SHALL, if an edge and cs_s rising are detected in the same cycle, process the edge first, which may complete the word, then enter IDLE.
REQ-026 SHALL ignore sclk edges in IDLE.
REQ-027 SHALL keep counter_trgt across cs cycles, because only rstn restores the default.

Reset
REQ-028 SHALL, when rstn=0 at a clk edge, set: state IDLE, counter 0, counter_trgt all ones (DATA_WIDTH-1 for power-of-2 widths), no pending update, shreg 0, data 0, data_valid 0, done 0, abort 0, overrun 0, and all synchronizer flops to cs=1, sclk=0, mosi=0.
REQ-029 SHALL, if rstn falls mid-word, drop the word without pulsing abort.

Configuration
REQ-030 SHALL compile overrun detection in only when macro SPI_SLAVE_RX_OVERRUN_DET_EN is defined.
REQ-031 SHALL, with SPI_SLAVE_RX_OVERRUN_DET_EN, set overrun when a word completes while data_valid=1 and data_ack=0, with the new word overwriting data; overrun SHALL clear only on reset.
REQ-032 SHALL, without SPI_SLAVE_RX_OVERRUN_DET_EN, tie overrun to 0 and instantiate no detection logic; the overwrite behaviour SHALL be unchanged.

Verification
REQ-033 SHALL cover: after reset, cs low, 32 edges sending 0xA5C3_0F81 -> done pulse, data=0xA5C30F81, data_valid=1 until data_ack.
REQ-034 SHALL cover: counter_in=7 with upd, then byte 0x3C sent -> data=0x0000003C after 8 edges, and counter returns to 0.
REQ-035 SHALL cover: cs rises after 5 of 8 bits -> abort pulse, data and data_valid unchanged, and the next full byte 0x81 is received correctly.
REQ-036 SHALL cover: two 8-bit words 0x11 then 0x22 with no data_ack, macro defined -> data=0x22, overrun=1; macro undefined -> overrun=0.
REQ-037 SHALL cover: counter_in_upd=3 issued mid 8-bit word -> the current word completes at 8 bits and the next word at 4 bits.
REQ-038 SHALL cover: rstn low for one cycle mid-word -> all outputs 0 next cycle, counter_trgt all ones, and abort not pulsed.
